// File: rtl/ram8_stack_ctrl_pkg.sv
// Shared op codes and FSM state encoding for the RAM8 stack controller.
package ram8_stack_ctrl_pkg;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10,
    RSP  = 2'b11
  } state_t;

endpackage

// File: rtl/ram8_stack_ctrl_stack_ptr.sv
// Stack pointer and occupancy counter; sp always equals count mod depth.
module stack_ptr
  import ram8_stack_ctrl_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] sp_m1,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
    end else if (clr) begin
      sp    <= '0;
      count <= '0;
    end else if (inc) begin
      sp    <= sp + 1'b1;
      count <= count + 1'b1;
    end else if (dec) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

  // The FSM only raises inc below full and dec above empty, so count never wraps.
  assign sp_m1 = sp - 1'b1;
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/ram8_stack_ctrl.sv
// LIFO controller driving an 8x16 RAM8 register file, with valid/ready
// command and response channels.
module ram8_stack_ctrl
  import ram8_stack_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  input  logic [WIDTH-1:0] ram_out
);

  state_t state, state_next;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             pop_q;
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_m1;
  logic             accept;
  logic             ptr_inc;
  logic             ptr_dec;
  logic             ptr_clr;

  assign accept  = cmd_valid && (state == IDLE);
  assign ptr_inc = (state == WR);
  assign ptr_dec = (state == RD) && pop_q;
  assign ptr_clr = accept && (cmd_op == OP_CLEAR);

  stack_ptr #(.AW(AW)) u_stack_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (ptr_inc),
    .dec   (ptr_dec),
    .clr   (ptr_clr),
    .sp    (sp),
    .sp_m1 (sp_m1),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_load   = 1'b0;
    ram_addr   = sp_m1;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_PUSH:         state_next = full  ? RSP : WR;
            OP_POP, OP_PEEK: state_next = empty ? RSP : RD;
            default:         state_next = RSP;
          endcase
        end
      end
      WR: begin
        ram_load   = 1'b1;
        ram_addr   = sp;
        state_next = RSP;
      end
      RD:  state_next = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Errors and clears answer straight from IDLE; pushes and reads fill the
  // response registers during their single WR/RD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (cmd_op)
              OP_PUSH: begin
                if (full) begin
                  rsp_err_q  <= 1'b1;
                  rsp_data_q <= '0;
                end else begin
                  data_q <= cmd_data;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  rsp_err_q  <= 1'b1;
                  rsp_data_q <= '0;
                end else begin
                  pop_q <= (cmd_op == OP_POP);
                end
              end
              default: begin
                rsp_err_q  <= 1'b0;
                rsp_data_q <= '0;
              end
            endcase
          end
        end
        WR: begin
          rsp_data_q <= data_q;
          rsp_err_q  <= 1'b0;
        end
        RD: begin
          rsp_data_q <= ram_out;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ram_in   = data_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_ram8_stack_ctrl.sv
// Self-checking bench: directed and random commands checked against a queue
// model of the stack, with a behavioural RAM8 attached to the RAM ports.
module tb_ram8_stack_ctrl;
  import ram8_stack_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [2:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_q[$];
  logic [15:0] mem [8];

  ram8_stack_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ram_addr  (ram_addr),
    .ram_in    (ram_in),
    .ram_load  (ram_load),
    .ram_out   (ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_load) mem[ram_addr] <= ram_in;
  assign ram_out = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags();
    int n;
    n = model_q.size();
    check("count", 32'(count), 32'(n));
    check("full",  32'(full),  32'(n == 8));
    check("empty", 32'(empty), 32'(n == 0));
  endtask

  // Issues one command, follows it through to the handshake, and compares
  // against the queue model. hold = cycles rsp_ready stays low in RSP.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input int hold);
    logic [15:0] exp_data;
    logic        exp_err;
    logic [2:0]  exp_addr;
    bit          slow;
    int          size;
    size     = model_q.size();
    exp_data = '0;
    exp_err  = 1'b0;
    slow     = 1'b0;
    exp_addr = '0;
    case (op)
      OP_PUSH: begin
        if (size == 8) exp_err = 1'b1;
        else begin
          exp_data = d;
          exp_addr = size[2:0];
          model_q.push_back(d);
          slow = 1'b1;
        end
      end
      OP_POP, OP_PEEK: begin
        if (size == 0) exp_err = 1'b1;
        else begin
          exp_data = (op == OP_POP) ? model_q.pop_back() : model_q[$];
          exp_addr = 3'(size - 1);
          slow = 1'b1;
        end
      end
      default: model_q.delete();
    endcase

    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 16'($urandom);

    if (slow) begin
      check("rsp_valid_busy", 32'(rsp_valid), 32'd0);
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check("ram_load",       32'(ram_load),  32'(op == OP_PUSH));
      check("ram_addr",       32'(ram_addr),  32'(exp_addr));
      if (op == OP_PUSH) check("ram_in", 32'(ram_in), 32'(d));
      tick();
    end else begin
      check("ram_load_none", 32'(ram_load), 32'd0);
    end

    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data",  32'(rsp_data),  32'(exp_data));
    check("rsp_err",   32'(rsp_err),   32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data",  32'(rsp_data),  32'(exp_data));
      check("hold_err",   32'(rsp_err),   32'(exp_err));
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_done", 32'(rsp_valid), 32'd0);
    check("cmd_ready_done", 32'(cmd_ready), 32'd1);
    check_flags();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_PUSH;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_ram_load",  32'(ram_load),  32'd0);
    check_flags();
    tick();
    tick();
    reset = 1'b0;

    do_cmd(OP_PUSH, 16'h1234, 0);
    do_cmd(OP_CLEAR, 16'h0, 0);

    for (int i = 1; i <= 8; i++) do_cmd(OP_PUSH, 16'(i), 0);
    do_cmd(OP_PUSH, 16'hFFFF, 0);
    for (int i = 0; i < 8; i++) do_cmd(OP_POP, 16'h0, 0);
    do_cmd(OP_POP, 16'h0, 0);

    do_cmd(OP_PUSH, 16'hBEEF, 0);
    do_cmd(OP_PEEK, 16'h0, 0);
    do_cmd(OP_PEEK, 16'h0, 1);
    do_cmd(OP_POP,  16'h0, 0);

    do_cmd(OP_PUSH, 16'h0A0A, 0);
    do_cmd(OP_PUSH, 16'h0B0B, 0);
    do_cmd(OP_PUSH, 16'h0C0C, 5);
    do_cmd(OP_CLEAR, 16'h0, 2);
    do_cmd(OP_POP,  16'h0, 0);

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      do_cmd(OP_PUSH, 16'($urandom), int'($urandom_range(0, 2)));
      else if (r < 7) do_cmd(OP_POP,  16'($urandom), int'($urandom_range(0, 2)));
      else if (r < 9) do_cmd(OP_PEEK, 16'($urandom), int'($urandom_range(0, 2)));
      else            do_cmd(OP_CLEAR, 16'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset asserted mid-cycle while a push response is pending.
    do_cmd(OP_CLEAR, 16'h0, 0);
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_data  = 16'hAAAA;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    check("pre_rst_data",  32'(rsp_data),  32'hAAAA);
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_cmd_ready", 32'(cmd_ready), 32'd1);
    check("async_rsp_data",  32'(rsp_data),  32'd0);
    check_flags();
    tick();
    reset = 1'b0;
    do_cmd(OP_POP,  16'h0, 0);
    do_cmd(OP_PUSH, 16'h5A5A, 0);
    do_cmd(OP_POP,  16'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
